// File: rtl/uart_mmio_if.sv
// ============================================================================
// Module   : uart_mmio_if
// Purpose  : CPU memory-stage bus plus UART TX/RX handshakes for uart_mmio_ctrl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_mmio_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  UARTDataIn;
    logic        UARTDataInValid;
    logic        UARTDataInReady;
    logic [7:0]  UARTDataOut;
    logic        UARTDataOutValid;
    logic        UARTDataOutReady;

    modport master (
        output MemWrite, MemRead, Address, WriteData,
        output UARTDataInReady, UARTDataOut, UARTDataOutValid,
        input  ReadData, UARTDataIn, UARTDataInValid, UARTDataOutReady
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData,
        input  UARTDataInReady, UARTDataOut, UARTDataOutValid,
        output ReadData, UARTDataIn, UARTDataInValid, UARTDataOutReady
    );
endinterface

`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
// ============================================================================
// Module   : uart_mmio_ctrl
// Purpose  : Memory-mapped UART controller with TX/RX FIFOs and TX drain FSM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_mmio_ctrl #(
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_mmio_if.slave   bus
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);

    localparam logic [TAW:0] c_tx_full = (TAW+1)'(TX_DEPTH);
    localparam logic [RAW:0] c_rx_full = (RAW+1)'(RX_DEPTH);

    localparam logic [31:0] c_addr_txrdy  = 32'h8000_0000;
    localparam logic [31:0] c_addr_rxrdy  = 32'h8000_0004;
    localparam logic [31:0] c_addr_txdata = 32'h8000_0008;
    localparam logic [31:0] c_addr_rxdata = 32'h8000_000C;
    localparam logic [31:0] c_addr_status = 32'h8000_0010;

    localparam logic [0:0] c_st_idle    = 1'b0;
    localparam logic [0:0] c_st_present = 1'b1;

    logic [0:0]   r_state, w_state_nxt;
    logic         w_tx_pop, w_tx_valid;

    logic [7:0]   r_tx_mem [TX_DEPTH];
    logic [TAW-1:0] r_tx_wptr, r_tx_rptr;
    logic [TAW:0] r_tx_fcnt, w_tx_count;
    logic [7:0]   r_tx_data;
    logic         r_tx_ovf;

    logic [7:0]   r_rx_mem [RX_DEPTH];
    logic [RAW-1:0] r_rx_wptr, r_rx_rptr;
    logic [RAW:0] r_rx_count;

    logic [31:0]  r_rdata, w_rdata_mux;

    logic w_wr, w_rd, w_tx_push_req, w_tx_push, w_tx_drop, w_ovf_clr;
    logic w_tx_empty, w_tx_full, w_present;
    logic w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_ready;
    logic w_unused_wdata;

    assign w_unused_wdata = &{1'b0, bus.WriteData[31:8]};

    // A simultaneous write wins over the read, so reads are qualified by !MemWrite
    assign w_wr          = bus.MemWrite;
    assign w_rd          = bus.MemRead & ~bus.MemWrite;
    assign w_tx_push_req = w_wr & (bus.Address == c_addr_txdata);
    assign w_ovf_clr     = w_wr & (bus.Address == c_addr_status);

    assign w_tx_empty = (r_tx_fcnt == '0);
    assign w_present  = (r_state == c_st_present);
    assign w_tx_count = r_tx_fcnt + {{TAW{1'b0}}, w_present};
    assign w_tx_full  = (w_tx_count == c_tx_full);
    assign w_tx_push  = w_tx_push_req & (~w_tx_full | w_tx_pop);
    assign w_tx_drop  = w_tx_push_req & w_tx_full & ~w_tx_pop;

    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_full  = (r_rx_count == c_rx_full);
    assign w_rx_ready = rst_n & ~w_rx_full;
    assign w_rx_push  = bus.UARTDataOutValid & w_rx_ready;
    assign w_rx_pop   = w_rd & (bus.Address == c_addr_rxdata) & ~w_rx_empty;

    // TX drain FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:    if (!w_tx_empty) w_state_nxt = c_st_present;
            c_st_present: if (bus.UARTDataInReady && w_tx_empty) w_state_nxt = c_st_idle;
            default:      w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_tx_pop   = 1'b0;
        w_tx_valid = 1'b0;
        case (r_state)
            c_st_idle:    w_tx_pop = ~w_tx_empty;
            c_st_present: begin
                w_tx_valid = 1'b1;
                w_tx_pop   = bus.UARTDataInReady & ~w_tx_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus.WriteData[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= bus.UARTDataOut;
    end

    // Storage count excludes the byte held for the transmitter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wptr <= '0;
            r_tx_rptr <= '0;
            r_tx_fcnt <= '0;
            r_tx_data <= '0;
            r_tx_ovf  <= 1'b0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + 1'b1;
                r_tx_data <= r_tx_mem[r_tx_rptr];
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_fcnt <= r_tx_fcnt + 1'b1;
                2'b01:   r_tx_fcnt <= r_tx_fcnt - 1'b1;
                default: r_tx_fcnt <= r_tx_fcnt;
            endcase
            if (w_tx_drop)      r_tx_ovf <= 1'b1;
            else if (w_ovf_clr) r_tx_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + 1'b1;
                2'b01:   r_rx_count <= r_rx_count - 1'b1;
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    always_comb begin
        w_rdata_mux = '0;
        case (bus.Address)
            c_addr_txrdy:  w_rdata_mux = {31'b0, ~w_tx_full};
            c_addr_rxrdy:  w_rdata_mux = {31'b0, ~w_rx_empty};
            c_addr_rxdata: w_rdata_mux = w_rx_empty ? 32'h0 : {24'b0, r_rx_mem[r_rx_rptr]};
            c_addr_status: w_rdata_mux = {16'b0, 8'(r_rx_count), 7'(w_tx_count), r_tx_ovf};
            default:       w_rdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rdata <= '0;
        else        r_rdata <= w_rd ? w_rdata_mux : 32'h0;
    end

    assign bus.ReadData         = r_rdata;
    assign bus.UARTDataIn       = r_tx_data;
    assign bus.UARTDataInValid  = w_tx_valid;
    assign bus.UARTDataOutReady = w_rx_ready;

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
// ============================================================================
// Module   : tb_uart_mmio_ctrl
// Purpose  : Directed self-checking bench for uart_mmio_ctrl (depths 4/4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_mmio_ctrl;
    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    uart_mmio_if u_if();

    uart_mmio_ctrl #(.TX_DEPTH(4), .RX_DEPTH(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
        u_if.MemWrite  = 1'b1;
        u_if.Address   = addr;
        u_if.WriteData = data;
        tick();
        u_if.MemWrite  = 1'b0;
    endtask

    task automatic mem_read(input logic [31:0] addr);
        u_if.MemRead = 1'b1;
        u_if.Address = addr;
        tick();
        u_if.MemRead = 1'b0;
    endtask

    logic [7:0] rx_bytes [4];
    logic [7:0] tx_bytes [3];
    int         valid_seen;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_total = 0;
        n_bad   = 0;
        rx_bytes[0] = 8'h5A; rx_bytes[1] = 8'hA5; rx_bytes[2] = 8'h11; rx_bytes[3] = 8'h22;
        u_if.MemWrite = 1'b0; u_if.MemRead = 1'b0;
        u_if.Address = '0; u_if.WriteData = '0;
        u_if.UARTDataInReady = 1'b0;
        u_if.UARTDataOut = '0; u_if.UARTDataOutValid = 1'b0;
        rst_n = 1'b0;

        // reset state
        repeat (3) tick();
        check_eq("rst_rdata", u_if.ReadData, 32'h0);
        check_eq("rst_valid", {31'b0, u_if.UARTDataInValid}, 32'h0);
        check_eq("rst_din", {24'b0, u_if.UARTDataIn}, 32'h0);
        check_eq("rst_oready", {31'b0, u_if.UARTDataOutReady}, 32'h0);
        rst_n = 1'b1;
        tick();
        check_eq("oready_after_rst", {31'b0, u_if.UARTDataOutReady}, 32'h1);
        mem_read(32'h8000_0000); check_eq("txrdy_init", u_if.ReadData, 32'h1);
        mem_read(32'h8000_0004); check_eq("rxrdy_init", u_if.ReadData, 32'h0);
        mem_read(32'h8000_0010); check_eq("status_init", u_if.ReadData, 32'h0);
        tick();
        check_eq("rdata_idle_zero", u_if.ReadData, 32'h0);

        // back-to-back drain with ready held high
        u_if.UARTDataInReady = 1'b1;
        mem_write(32'h8000_0008, 32'hFFFF_FF41);
        check_eq("b2b_valid0", {31'b0, u_if.UARTDataInValid}, 32'h0);
        mem_write(32'h8000_0008, 32'h0000_0042);
        check_eq("b2b_din41", {23'b0, u_if.UARTDataInValid, u_if.UARTDataIn}, 32'h141);
        mem_write(32'h8000_0008, 32'h0000_0043);
        check_eq("b2b_din42", {23'b0, u_if.UARTDataInValid, u_if.UARTDataIn}, 32'h142);
        tick();
        check_eq("b2b_din43", {23'b0, u_if.UARTDataInValid, u_if.UARTDataIn}, 32'h143);
        tick();
        check_eq("b2b_valid_drop", {31'b0, u_if.UARTDataInValid}, 32'h0);
        mem_read(32'h8000_0010); check_eq("b2b_status", u_if.ReadData, 32'h0);

        // overflow with transmitter stalled
        u_if.UARTDataInReady = 1'b0;
        for (int i = 0; i < 4; i++) mem_write(32'h8000_0008, 32'h61 + i);
        mem_read(32'h8000_0000); check_eq("txrdy_full", u_if.ReadData, 32'h0);
        mem_write(32'h8000_0008, 32'h65);
        mem_read(32'h8000_0010); check_eq("status_ovf", u_if.ReadData, 32'h9);
        check_eq("ovf_din61", {23'b0, u_if.UARTDataInValid, u_if.UARTDataIn}, 32'h161);
        mem_write(32'h8000_0010, 32'hFFFF_FFFF);
        mem_read(32'h8000_0010); check_eq("status_ovf_clr", u_if.ReadData, 32'h8);
        tx_bytes[0] = 8'h62; tx_bytes[1] = 8'h63; tx_bytes[2] = 8'h64;
        u_if.UARTDataInReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("drain_%0d", i), {23'b0, u_if.UARTDataInValid, u_if.UARTDataIn},
                     {23'b0, 1'b1, tx_bytes[i]});
        end
        tick();
        check_eq("drain_done", {31'b0, u_if.UARTDataInValid}, 32'h0);
        mem_read(32'h8000_0010); check_eq("drain_status", u_if.ReadData, 32'h0);

        // RX fill to full, 5th byte back-pressured
        u_if.UARTDataOutValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_if.UARTDataOut = rx_bytes[i];
            tick();
        end
        u_if.UARTDataOut = 8'h33;
        check_eq("rx_full_ready", {31'b0, u_if.UARTDataOutReady}, 32'h0);
        mem_read(32'h8000_0004); check_eq("rxrdy_full", u_if.ReadData, 32'h1);
        mem_read(32'h8000_0010); check_eq("status_rx4", u_if.ReadData, 32'h400);
        mem_read(32'h8000_000C); check_eq("rx_pop0", u_if.ReadData, 32'h5A);
        check_eq("rx_ready_reopen", {31'b0, u_if.UARTDataOutReady}, 32'h1);
        mem_read(32'h8000_000C); check_eq("rx_pop1", u_if.ReadData, 32'hA5);
        u_if.UARTDataOutValid = 1'b0;
        mem_read(32'h8000_000C); check_eq("rx_pop2", u_if.ReadData, 32'h11);
        mem_read(32'h8000_000C); check_eq("rx_pop3", u_if.ReadData, 32'h22);
        mem_read(32'h8000_000C); check_eq("rx_pop4", u_if.ReadData, 32'h33);
        mem_read(32'h8000_0004); check_eq("rxrdy_empty", u_if.ReadData, 32'h0);
        mem_read(32'h8000_000C); check_eq("rx_pop_empty", u_if.ReadData, 32'h0);
        mem_read(32'h8000_0010); check_eq("status_rx0", u_if.ReadData, 32'h0);

        // unmapped accesses and write/read collision
        mem_read(32'h8000_1234); check_eq("unmapped_rd", u_if.ReadData, 32'h0);
        mem_write(32'h8000_0004, 32'hFFFF_FFFF);
        mem_read(32'h8000_0010); check_eq("ro_write_ignored", u_if.ReadData, 32'h0);
        mem_read(32'h8000_0000); check_eq("txrdy_after_ro", u_if.ReadData, 32'h1);
        u_if.MemRead = 1'b1;
        mem_write(32'h8000_0000, 32'h0);
        u_if.MemRead = 1'b0;
        check_eq("wr_rd_collision", u_if.ReadData, 32'h0);

        // asynchronous reset mid-PRESENT with bytes queued both ways
        u_if.UARTDataInReady = 1'b0;
        for (int i = 0; i < 3; i++) mem_write(32'h8000_0008, 32'h71 + i);
        u_if.UARTDataOutValid = 1'b1;
        u_if.UARTDataOut = 8'h81; tick();
        u_if.UARTDataOut = 8'h82; tick();
        u_if.UARTDataOutValid = 1'b0;
        mem_read(32'h8000_0010); check_eq("status_pre_rst", u_if.ReadData, 32'h206);
        check_eq("din_pre_rst", {23'b0, u_if.UARTDataInValid, u_if.UARTDataIn}, 32'h171);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rdata", u_if.ReadData, 32'h0);
        check_eq("async_din", {23'b0, u_if.UARTDataInValid, u_if.UARTDataIn}, 32'h0);
        check_eq("async_oready", {31'b0, u_if.UARTDataOutReady}, 32'h0);
        repeat (2) tick();
        rst_n = 1'b1;
        u_if.UARTDataInReady = 1'b1;
        valid_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (u_if.UARTDataInValid) valid_seen++;
        end
        check_eq("no_stale_tx", valid_seen, 32'h0);
        mem_read(32'h8000_0010); check_eq("status_post_rst", u_if.ReadData, 32'h0);
        mem_read(32'h8000_0004); check_eq("rxrdy_post_rst", u_if.ReadData, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Memory-mapped UART controller between the CPU memory stage and the UART transmitter/receiver.
- Buffers CPU-written bytes in a TX FIFO and drains them to the UART transmitter through a valid/ready handshake.
- Buffers received bytes in an RX FIFO and answers CPU status and data reads in the 0x8000_00xx I/O window with registered read data.

Parameters:
TX_DEPTH, 4, TX FIFO entries; power of 2, 2..16
RX_DEPTH, 4, RX FIFO entries; power of 2, 2..16

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
MemWrite  in  1  CPU store strobe, one cycle per store
MemRead  in  1  CPU load strobe, one cycle per load
Address  in  32  CPU byte address
WriteData  in  32  CPU store data
ReadData  out  32  registered load data, valid the cycle after MemRead
UARTDataIn  out  8  byte to UART transmitter
UARTDataInValid  out  1  UARTDataIn is valid
UARTDataInReady  in  1  transmitter accepts the byte this cycle
UARTDataOut  in  8  byte from UART receiver
UARTDataOutValid  in  1  receiver byte is valid
UARTDataOutReady  out  1  controller accepts the receiver byte

Behaviour:
- Reset (rst_n low, asynchronous):
  - both FIFOs empty; TX FSM in IDLE; sticky tx_ovf = 0.
  - ReadData = 0; UARTDataIn = 0; UARTDataInValid = 0; UARTDataOutReady = 0 while reset is asserted.
  - Reset during a pending TX handshake drops the byte.
- Register map (full 32-bit compare):
  - 0x80000000 R: {31'b0, tx_not_full}
  - 0x80000004 R: {31'b0, rx_not_empty}
  - 0x80000008 W: push WriteData[7:0] into the TX FIFO
  - 0x8000000C R: {24'b0, RX head byte}, then pop
  - 0x80000010 R: {16'b0, rx_count[7:0], tx_count[6:0], tx_ovf}
  - 0x80000010 W: clear tx_ovf (write data ignored)
  - Any other address: reads return 0; writes are ignored.
  - MemWrite and MemRead are never asserted together. If they are, MemWrite wins and ReadData = 0.
- Read timing:
  - ReadData is updated on the clock edge that samples MemRead.
  - Cycles with no MemRead load 0 into ReadData.
  - A read of 0x8000000C pops the RX FIFO on the same edge.
  - Reading 0x8000000C with the RX FIFO empty returns 0 and does not pop.
- TX FIFO push:
  - A push while full is dropped and sets tx_ovf.
  - Exception: if the FSM pops in the same cycle, the push is accepted and tx_count is unchanged.
- TX drain FSM:
  - IDLE: if the FIFO is non-empty, latch the head into UARTDataIn, pop it, and go to PRESENT.
  - PRESENT: hold UARTDataInValid = 1 and keep UARTDataIn stable until UARTDataInReady = 1.
  - On accept: if the FIFO is non-empty, reload the next head and pop in the same cycle, staying in PRESENT (back-to-back, no bubble). Otherwise go to IDLE and drop Valid.
  - tx_count includes the byte held in PRESENT. tx_not_full = (tx_count < TX_DEPTH).
- RX FIFO:
  - UARTDataOutReady = !rx_full, combinational on the registered count.
  - Push on UARTDataOutValid & UARTDataOutReady.
  - Simultaneous CPU pop and UART push: both happen. When full, the pop does not open Ready in the same cycle.
  - No overflow is possible because the receiver is back-pressured.
- Pointer rules:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Counts are log2(DEPTH)+1 bits, zero-extended into the status fields.

Test Plan:
- Reset, then read 0x80000000, 0x80000004 and 0x80000010 -> ReadData = 1, 0, 0; UARTDataInValid = 0; UARTDataOutReady = 1.
- Store 0x41, 0x42, 0x43 to 0x80000008 with UARTDataInReady held 1 -> UARTDataIn presents 0x41, 0x42, 0x43 on consecutive cycles with Valid continuously high, then Valid drops; tx_count returns to 0.
- UARTDataInReady = 0, store 5 bytes (TX_DEPTH = 4) -> 0x80000000 reads 0 after the 4th store; 0x80000010 reads tx_count = 4 and tx_ovf = 1; the 5th byte never appears. Write 0x80000010 -> tx_ovf = 0.
- Receiver pushes 0x5A, 0xA5, 0x11, 0x22, with Valid held on a 5th byte -> UARTDataOutReady = 0 after 4. Reads of 0x8000000C return 0x5A, 0xA5, 0x11, 0x22 in order; Ready reasserts the cycle after the first pop; the 5th byte is then accepted.
- Read 0x8000000C with RX empty -> 0, no count change. Read 0x80001234 -> 0. Store to 0x80000004 -> no state change.
- Assert rst_n low mid-PRESENT with 3 TX and 2 RX bytes queued -> all outputs 0 immediately (asynchronous); after release, FIFOs empty and no stale byte is transmitted.
